// File: rtl/uvmt_cv32e40s_obi_arb_pkg.sv
// ============================================================================
// uvmt_cv32e40s_obi_arb_pkg : shared types for the instr/data OBI arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package uvmt_cv32e40s_obi_arb_pkg;

  typedef enum logic {
    OBI_SRC_INSTR,
    OBI_SRC_DATA
  } obi_src_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOCK_I,
    ARB_LOCK_D
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/uvmt_cv32e40s_obi_arb_fifo.sv
// ============================================================================
// uvmt_cv32e40s_obi_arb_fifo : in-order source-tag FIFO for outstanding txns
// Revision: 1.0
// ============================================================================
`default_nettype none

module uvmt_cv32e40s_obi_arb_fifo
  import uvmt_cv32e40s_obi_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  obi_src_e                     push_src,
  input  logic                         pop,
  output obi_src_e                     head_src,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  obi_src_e          entries [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_en;
  logic              pop_en;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign head_src = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) begin
      entries[wr_ptr] <= push_src;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uvmt_cv32e40s_obi_arbiter.sv
// ============================================================================
// uvmt_cv32e40s_obi_arbiter : round-robin instr/data OBI arbiter onto one port
// Revision: 1.0
// ============================================================================
`default_nettype none

module uvmt_cv32e40s_obi_arbiter
  import uvmt_cv32e40s_obi_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   instr_req_i,
  input  logic [ADDR_WIDTH-1:0]                  instr_addr_i,
  output logic                                   instr_gnt_o,
  output logic                                   instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  instr_rdata_o,
  output logic                                   instr_err_o,
  input  logic                                   data_req_i,
  input  logic [ADDR_WIDTH-1:0]                  data_addr_i,
  input  logic                                   data_we_i,
  input  logic [DATA_WIDTH/8-1:0]                data_be_i,
  input  logic [DATA_WIDTH-1:0]                  data_wdata_i,
  output logic                                   data_gnt_o,
  output logic                                   data_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  data_rdata_o,
  output logic                                   data_err_o,
  output logic                                   mem_req_o,
  output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
  output logic                                   mem_we_o,
  output logic [DATA_WIDTH/8-1:0]                mem_be_o,
  output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
  input  logic                                   mem_gnt_i,
  input  logic                                   mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
  input  logic                                   mem_err_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   protocol_err_o
);

  localparam logic [1:0] ST_IDLE   = ARB_IDLE;
  localparam logic [1:0] ST_LOCK_I = ARB_LOCK_I;
  localparam logic [1:0] ST_LOCK_D = ARB_LOCK_D;

  logic [1:0] state;
  logic [1:0] state_next;
  obi_src_e   rr_last;
  obi_src_e   sel;
  logic       sel_req;
  logic       handshake;
  logic       resp_fwd;
  logic       resp_spurious;
  logic       lock_drop;
  obi_src_e   head_src;
  logic       fifo_full;
  logic       fifo_empty;

  // Selection is frozen while a lock is held; otherwise round-robin on ties.
  always_comb begin
    sel     = OBI_SRC_INSTR;
    sel_req = 1'b0;
    case (state)
      ST_LOCK_I: begin
        sel     = OBI_SRC_INSTR;
        sel_req = instr_req_i;
      end
      ST_LOCK_D: begin
        sel     = OBI_SRC_DATA;
        sel_req = data_req_i;
      end
      default: begin
        if (instr_req_i && data_req_i) begin
          sel = (rr_last == OBI_SRC_DATA) ? OBI_SRC_INSTR : OBI_SRC_DATA;
        end else if (data_req_i) begin
          sel = OBI_SRC_DATA;
        end
        sel_req = instr_req_i || data_req_i;
      end
    endcase
  end

  assign mem_req_o   = rst_n && sel_req && !fifo_full;
  assign handshake   = mem_req_o && mem_gnt_i;
  assign instr_gnt_o = handshake && (sel == OBI_SRC_INSTR);
  assign data_gnt_o  = handshake && (sel == OBI_SRC_DATA);

  assign mem_addr_o  = !rst_n ? '0 : (sel == OBI_SRC_DATA) ? data_addr_i : instr_addr_i;
  assign mem_we_o    = rst_n && (sel == OBI_SRC_DATA) && data_we_i;
  assign mem_be_o    = !rst_n ? '0 : (sel == OBI_SRC_DATA) ? data_be_i : '1;
  assign mem_wdata_o = (rst_n && (sel == OBI_SRC_DATA)) ? data_wdata_i : '0;

  // A response with nothing outstanding is dropped and flagged.
  assign resp_fwd      = rst_n && mem_rvalid_i && !fifo_empty;
  assign resp_spurious = rst_n && mem_rvalid_i && fifo_empty;
  assign lock_drop     = rst_n && (state != ST_IDLE) && !sel_req;

  assign instr_rvalid_o = resp_fwd && (head_src == OBI_SRC_INSTR);
  assign data_rvalid_o  = resp_fwd && (head_src == OBI_SRC_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
  assign instr_err_o    = instr_rvalid_o && mem_err_i;
  assign data_err_o     = data_rvalid_o && mem_err_i;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_next = (sel == OBI_SRC_INSTR) ? ST_LOCK_I : ST_LOCK_D;
        end
      end
      ST_LOCK_I, ST_LOCK_D: begin
        if (!sel_req || mem_gnt_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rr_last        <= OBI_SRC_DATA;
      protocol_err_o <= 1'b0;
    end else begin
      state <= state_next;
      if (handshake) begin
        rr_last <= sel;
      end
      if (resp_spurious || lock_drop) begin
        protocol_err_o <= 1'b1;
      end
    end
  end

  uvmt_cv32e40s_obi_arb_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (handshake),
    .push_src (sel),
    .pop      (resp_fwd),
    .head_src (head_src),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_uvmt_cv32e40s_obi_arbiter.sv
// ============================================================================
// tb_uvmt_cv32e40s_obi_arbiter : directed + random check against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uvmt_cv32e40s_obi_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;
  logic [1:0]  outstanding_o;
  logic        protocol_err_o;

  uvmt_cv32e40s_obi_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .outstanding_o  (outstanding_o),
    .protocol_err_o (protocol_err_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: queue of owners awaiting a response (0=instr, 1=data),
  // the source currently holding an ungranted address phase (0 none, 1 I, 2 D),
  // the last granted source and the sticky error flag.
  bit q[$];
  int held     = 0;
  bit last_d   = 1'b1;
  bit perr     = 1'b0;
  bit exp_ig   = 1'b0;
  bit exp_dg   = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held   = 0;
    last_d = 1'b1;
    perr   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    instr_req_i  = 1'b1;
    data_req_i   = 1'b1;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    #1;
    check_val("rst_mem_req", mem_req_o, 0);
    check_val("rst_instr_gnt", instr_gnt_o, 0);
    check_val("rst_data_gnt", data_gnt_o, 0);
    check_val("rst_instr_rvalid", instr_rvalid_o, 0);
    check_val("rst_data_rvalid", data_rvalid_o, 0);
    check_val("rst_mem_addr", mem_addr_o, 0);
    model_reset();
  endtask

  task automatic do_cycle(input bit ir, input logic [31:0] ia,
                          input bit dr, input logic [31:0] da, input bit dwe,
                          input logic [3:0] dbe, input logic [31:0] dwd,
                          input bit g, input bit rv, input logic [31:0] rd, input bit er);
    bit full, req, src_d, ereq, fwd, head_d;
    @(negedge clk);
    rst_n = 1'b1;
    instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_addr_i = da; data_we_i = dwe; data_be_i = dbe; data_wdata_i = dwd;
    mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = er;
    #1;
    full = (q.size() >= MAXO);
    if (held == 1)      begin src_d = 1'b0; req = ir; end
    else if (held == 2) begin src_d = 1'b1; req = dr; end
    else begin
      req   = ir || dr;
      src_d = (ir && dr) ? !last_d : dr;
    end
    ereq   = req && !full;
    exp_ig = ereq && g && !src_d;
    exp_dg = ereq && g && src_d;
    fwd    = rv && (q.size() > 0);
    head_d = fwd ? q[0] : 1'b0;

    check_val("mem_req", mem_req_o, ereq);
    check_val("instr_gnt", instr_gnt_o, exp_ig);
    check_val("data_gnt", data_gnt_o, exp_dg);
    if (ereq) begin
      check_val("mem_addr", mem_addr_o, src_d ? da : ia);
      check_val("mem_we", mem_we_o, src_d ? dwe : 1'b0);
      check_val("mem_be", mem_be_o, src_d ? dbe : 4'hF);
      check_val("mem_wdata", mem_wdata_o, src_d ? dwd : 32'h0);
    end
    check_val("outstanding", outstanding_o, q.size());
    check_val("protocol_err", protocol_err_o, perr);
    check_val("instr_rvalid", instr_rvalid_o, fwd && !head_d);
    check_val("data_rvalid", data_rvalid_o, fwd && head_d);
    if (fwd) begin
      check_val("instr_rdata", instr_rdata_o, head_d ? 32'h0 : rd);
      check_val("data_rdata", data_rdata_o, head_d ? rd : 32'h0);
      check_val("instr_err", instr_err_o, !head_d && er);
      check_val("data_err", data_err_o, head_d && er);
    end

    if (fwd)      void'(q.pop_front());
    else if (rv)  perr = 1'b1;
    if (ereq && g) begin
      q.push_back(src_d);
      last_d = src_d;
    end
    if (held != 0 && !req) begin
      perr = 1'b1;
      held = 0;
    end else if (ereq && !g) begin
      held = src_d ? 2 : 1;
    end else begin
      held = 0;
    end
  endtask

  initial begin
    bit ir, dr, dwe, ipend, dpend;
    logic [31:0] ia, da, dwd;
    logic [3:0] dbe;

    // Single instruction read, response two cycles after grant
    do_reset();
    do_cycle(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check_val("t1_gnt", exp_ig, 1);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t1_outstanding", outstanding_o, 1);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    check_val("t1_rdata", instr_rdata_o, 32'hDEADBEEF);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Both request every cycle, grant always: I,D,I,D with in-order returns
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_cycle(1, 32'h200 + i, 1, 32'h300 + i, 1, 4'h3, 32'hA000 + i, 1,
               (i >= 1), 32'hB000 + i, (i == 3));
      check_val("t2_alt_instr", instr_gnt_o, (i % 2) == 0);
    end

    // Data write held ungranted 3 cycles while instruction also requests
    do_reset();
    do_cycle(0, 32'h40, 1, 32'h800, 1, 4'hC, 32'h1234_5678, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      do_cycle(1, 32'h40, 1, 32'h800, 1, 4'hC, 32'h1234_5678, 0, 0, 0, 0);
    do_cycle(1, 32'h40, 1, 32'h800, 1, 4'hC, 32'h1234_5678, 1, 0, 0, 0);
    check_val("t3_data_gnt", data_gnt_o, 1);
    do_cycle(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Full: third request blocked, rvalid that cycle does not bypass
    do_reset();
    do_cycle(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    do_cycle(1, 32'h14, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    do_cycle(1, 32'h18, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check_val("t4_blocked", mem_req_o, 0);
    do_cycle(1, 32'h18, 0, 0, 0, 0, 0, 1, 1, 32'h11, 0);
    check_val("t4_no_bypass", instr_gnt_o, 0);
    do_cycle(1, 32'h18, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check_val("t4_gnt_after", instr_gnt_o, 1);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33, 0);

    // Spurious response with nothing outstanding
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44, 0);
    for (int i = 0; i < 3; i++)
      do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t5_sticky", protocol_err_o, 1);

    // Reset with 2 outstanding; next tie goes to instr; late rvalid flagged
    do_cycle(1, 32'h50, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    do_cycle(0, 0, 1, 32'h60, 0, 4'hF, 0, 1, 0, 0, 0);
    do_reset();
    do_cycle(1, 32'h70, 1, 32'h74, 0, 4'hF, 0, 1, 1, 32'h55, 0);
    check_val("t6_tie_instr", instr_gnt_o, 1);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Locked source drops its request before grant
    do_reset();
    do_cycle(0, 0, 1, 32'h90, 0, 4'hF, 0, 0, 0, 0, 0);
    do_cycle(1, 32'h94, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    do_cycle(1, 32'h94, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check_val("t7_err_set", protocol_err_o, 1);

    // Randomized traffic with a well-behaved memory
    do_reset();
    ipend = 0; dpend = 0; ir = 0; dr = 0; ia = 0; da = 0; dwe = 0; dbe = 0; dwd = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ipend) begin
        ir = ($urandom_range(0, 2) != 0);
        ia = $urandom;
      end
      if (!dpend) begin
        dr  = ($urandom_range(0, 2) != 0);
        da  = $urandom;
        dwe = $urandom_range(0, 1);
        dbe = 4'($urandom);
        dwd = $urandom;
      end
      do_cycle(ir, ia, dr, da, dwe, dbe, dwd, ($urandom_range(0, 3) != 0),
               (q.size() > 0) && ($urandom_range(0, 2) != 0), $urandom,
               ($urandom_range(0, 7) == 0));
      ipend = ir && !exp_ig;
      dpend = dr && !exp_dg;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
